// File: rtl/arith_unit_scheduler_if.sv
// Request/response/ArithmeticUnit bundle for arith_unit_scheduler.
// The master side is the environment (requesters, AU, consumer); the slave side is the scheduler.
interface arith_unit_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       ReqValid;
  logic [NUM_REQ-1:0]       ReqReady;
  logic [NUM_REQ*WIDTH-1:0] ReqA;
  logic [NUM_REQ*WIDTH-1:0] ReqB;
  logic [NUM_REQ*2-1:0]     ReqOpSel;
  logic [WIDTH-1:0]         AU_A;
  logic [WIDTH-1:0]         AU_B;
  logic [1:0]               AU_OpSel;
  logic [WIDTH-1:0]         AU_Result;
  logic                     AU_Overflow;
  logic                     RspValid;
  logic                     RspReady;
  logic [ID_W-1:0]          RspId;
  logic [WIDTH-1:0]         RspResult;
  logic                     RspOverflow;
  logic                     Busy;

  modport master (
    output ReqValid, ReqA, ReqB, ReqOpSel, AU_Result, AU_Overflow, RspReady,
    input  ReqReady, AU_A, AU_B, AU_OpSel, RspValid, RspId, RspResult, RspOverflow, Busy
  );

  modport slave (
    input  ReqValid, ReqA, ReqB, ReqOpSel, AU_Result, AU_Overflow, RspReady,
    output ReqReady, AU_A, AU_B, AU_OpSel, RspValid, RspId, RspResult, RspOverflow, Busy
  );
endinterface

// File: rtl/arith_unit_scheduler.sv
// Round-robin scheduler sharing one combinational ArithmeticUnit between NUM_REQ requesters.
// state | meaning: IDLE = arbitrate/accept, EXEC = AU settling, RESP = hold response until consumed.
module arith_unit_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ID_W    = 2
) (
  input logic                  clk,
  input logic                  rst,
  arith_unit_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_au_a;
  logic [WIDTH-1:0] r_au_b;
  logic [1:0]       r_au_opsel;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_ovf;
  logic             r_rsp_valid;
  logic             r_busy;

  logic               w_found;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_next;
  logic [ID_W-1:0]    w_sel;
  logic [NUM_REQ-1:0] w_ready;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [1:0]         w_op;

  // Search starts at rr_ptr so the last-served requester ends up lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sel = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && bus.ReqValid[w_sel]) begin
        w_found = 1'b1;
        w_win   = w_sel;
      end
    end
  end

  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_win) begin
        w_a  = bus.ReqA[i*WIDTH +: WIDTH];
        w_b  = bus.ReqB[i*WIDTH +: WIDTH];
        w_op = bus.ReqOpSel[i*2 +: 2];
      end
    end
  end

  assign w_next  = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  assign w_ready = (r_state == IDLE && !rst && w_found) ? (NUM_REQ'(1) << w_win) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_rsp_id     <= '0;
      r_au_a       <= '0;
      r_au_b       <= '0;
      r_au_opsel   <= '0;
      r_rsp_result <= '0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_au_a     <= w_a;
            r_au_b     <= w_b;
            r_au_opsel <= w_op;
            r_rsp_id   <= w_win;
            r_rr_ptr   <= w_next;
            r_busy     <= 1'b1;
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_result <= bus.AU_Result;
          r_rsp_ovf    <= bus.AU_Overflow;
          r_rsp_valid  <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (bus.RspReady) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.ReqReady    = w_ready;
  assign bus.AU_A        = r_au_a;
  assign bus.AU_B        = r_au_b;
  assign bus.AU_OpSel    = r_au_opsel;
  assign bus.RspValid    = r_rsp_valid;
  assign bus.RspId       = r_rsp_id;
  assign bus.RspResult   = r_rsp_result;
  assign bus.RspOverflow = r_rsp_ovf;
  assign bus.Busy        = r_busy;
endmodule
